// File: rtl/debounce_pkg.sv
// Shared types for the debounce/edge detector.
// Four-state level filter encoding.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    CHK_HIGH  = 2'd1,
    IDLE_HIGH = 2'd2,
    CHK_LOW   = 2'd3
  } state_t;

endpackage

// File: rtl/debounce_edge_stab_counter.sv
// Stability counter: counts consecutive qualifying samples.
// at_limit marks the last sample before a level is accepted.
module stab_counter #(
  parameter int STABLE_CYCLES = 8,
  parameter int CNT_WIDTH     = $clog2(STABLE_CYCLES + 1)
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 clear,
  input  logic                 count_enable,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 at_limit
);

  // Clear wins over enable; reset clears like a forced clear.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (count_enable) begin
      cnt <= cnt + CNT_WIDTH'(1);
    end
  end

  // Final qualifying sample is about to be taken.
  always_comb begin
    at_limit = (cnt == CNT_WIDTH'(STABLE_CYCLES - 1));
  end

endmodule

// File: rtl/debounce_edge.sv
// Debounced level with rise/fall strobes and a
// saturating rising-event counter.
module debounce_edge
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 8,
  parameter int EVT_WIDTH     = 8
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 sync_in,
  input  logic                 clear_cnt,
  output logic                 level_out,
  output logic                 rise_pulse,
  output logic                 fall_pulse,
  output logic [EVT_WIDTH-1:0] rise_count
);

  localparam int CNT_WIDTH = $clog2(STABLE_CYCLES + 1);

  state_t                 state;
  state_t                 next_state;
  logic                   cnt_clr;
  logic                   cnt_en;
  logic                   at_limit;
  logic                   rise_nxt;
  logic                   fall_nxt;
  logic                   level_nxt;
  logic [CNT_WIDTH-1:0]   cnt;

  stab_counter #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .CNT_WIDTH     (CNT_WIDTH)
  ) u_stab (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (cnt_clr),
    .count_enable (cnt_en),
    .cnt          (cnt),
    .at_limit     (at_limit)
  );

  // Next state, counter control and strobe decisions.
  always_comb begin
    next_state = state;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    rise_nxt   = 1'b0;
    fall_nxt   = 1'b0;
    unique case (state)
      IDLE_LOW: begin
        if (sync_in) begin
          next_state = CHK_HIGH;
          cnt_en     = 1'b1;
        end else begin
          cnt_clr = 1'b1;
        end
      end
      CHK_HIGH: begin
        if (!sync_in) begin
          next_state = IDLE_LOW;
          cnt_clr    = 1'b1;
        end else if (at_limit) begin
          next_state = IDLE_HIGH;
          cnt_clr    = 1'b1;
          rise_nxt   = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      IDLE_HIGH: begin
        if (!sync_in) begin
          next_state = CHK_LOW;
          cnt_en     = 1'b1;
        end else begin
          cnt_clr = 1'b1;
        end
      end
      CHK_LOW: begin
        if (sync_in) begin
          next_state = IDLE_HIGH;
          cnt_clr    = 1'b1;
        end else if (at_limit) begin
          next_state = IDLE_LOW;
          cnt_clr    = 1'b1;
          fall_nxt   = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: begin
        next_state = IDLE_LOW;
        cnt_clr    = 1'b1;
      end
    endcase
    level_nxt = (next_state == IDLE_HIGH) ||
                (next_state == CHK_LOW);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state <= IDLE_LOW;
    end else begin
      state <= next_state;
    end
  end

  // Registered level and one-cycle strobes.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      level_out  <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      level_out  <= level_nxt;
      rise_pulse <= rise_nxt;
      fall_pulse <= fall_nxt;
    end
  end

  // Saturating rise counter; clear beats a same-edge rise.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      rise_count <= '0;
    end else if (clear_cnt) begin
      rise_count <= '0;
    end else if (rise_nxt &&
                 (rise_count != {EVT_WIDTH{1'b1}})) begin
      rise_count <= rise_count + EVT_WIDTH'(1);
    end
  end

endmodule
